hdmi_timing_ctrl: RTL and testbench
===================================

HDMI_TIMING_CTRL -- requirements
Module: hdmi_timing_ctrl

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-002 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-003 SHALL have parameter H_VALID, default 640, active pixels per line.
REQ-004 SHALL have parameter H_TOTAL, default 800, pixels per line.
REQ-005 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-006 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-007 SHALL have parameter V_VALID, default 480, active lines per frame.
REQ-008 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-009 SHALL have parameter SYNC_POL, default 1, active level of hsync/vsync.
REQ-010 SHALL have port vga_clk, input, 1, pixel clock; all logic on its rising edge.
REQ-011 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-012 SHALL have port locked, input, 1, PLL lock, synchronous to vga_clk.
REQ-013 SHALL have port enable, input, 1, request to run video timing.
REQ-014 SHALL have port hsync, output, 1, to encoder hsync.
REQ-015 SHALL have port vsync, output, 1, to encoder vsync.
REQ-016 SHALL have port rgb_valid, output, 1, to encoder rgb_valid.
REQ-017 SHALL have port pix_data_req, output, 1, pixel request to the pattern source, one cycle ahead of rgb_valid.
REQ-018 SHALL have port pix_x, output, 10, active column of the requested pixel.
REQ-019 SHALL have port pix_y, output, 10, active row of the requested pixel.
REQ-020 SHALL have port frame_start, output, 1, one-cycle pulse at h_cnt=0, v_cnt=0 in RUN.
REQ-021 SHALL have port busy, output, 1, high when the state is RUN or DRAIN.

Function
REQ-022 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-023 SHALL have internal counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1).
REQ-024 SHALL count only in RUN/DRAIN: h_cnt increments each cycle, wraps H_TOTAL-1→0 and then increments v_cnt; v_cnt wraps V_TOTAL-1→0.
REQ-025 SHALL transition IDLE→RUN when locked=1 and enable=1, with h_cnt=v_cnt=0 on the first RUN cycle.
REQ-026 SHALL transition RUN→DRAIN when enable=0 and locked=1.
REQ-027 SHALL transition DRAIN→RUN when enable returns to 1 before the frame end, with no counter disturbance.
REQ-028 SHALL transition DRAIN→IDLE on the cycle after h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, completing the frame.
REQ-029 SHALL transition any state→IDLE on the next edge when locked=0; counters clear to 0 and outputs go inactive on that edge.
REQ-030 SHALL hold counters at 0 in IDLE.
REQ-031 SHALL drive hsync=SYNC_POL when h_cnt<H_SYNC in RUN/DRAIN, else ~SYNC_POL.
REQ-032 SHALL drive vsync=SYNC_POL when v_cnt<V_SYNC in RUN/DRAIN, else ~SYNC_POL.
REQ-033 SHALL assert rgb_valid when H_SYNC+H_BACK ≤ h_cnt < H_SYNC+H_BACK+H_VALID and V_SYNC+V_BACK ≤ v_cnt < V_SYNC+V_BACK+V_VALID.
REQ-034 SHALL assert pix_data_req with the same window shifted one h_cnt earlier, with no line wrap.
REQ-035 SHALL drive pix_x=h_cnt-(H_SYNC+H_BACK)+1 and pix_y=v_cnt-(V_SYNC+V_BACK) while pix_data_req=1, else 0.
REQ-036 SHALL register all outputs so they are glitch-free; the value corresponds to the counter value of the same cycle.
REQ-037 SHALL make the relative timing of hsync/vsync/rgb_valid exact, because the encoder applies an equal fixed 2-cycle delay to all three.
REQ-038 SHALL make frame_start and busy follow the FSM state of the same cycle.

Reset
REQ-039 SHALL, while sys_rst_n=0, reset state to IDLE, h_cnt/v_cnt to 0, hsync/vsync to ~SYNC_POL, and rgb_valid, pix_data_req, pix_x, pix_y, frame_start and busy to 0.
REQ-040 SHALL assert reset asynchronously and release it synchronously to vga_clk; reset mid-frame aborts the frame with no further active pixels.

Verification
REQ-041 SHALL verify: locked=1, enable=1 after reset → frame_start on the first RUN cycle; hsync high for 96 cycles in each 800-cycle line; vsync high for 1600 cycles per 420000-cycle frame.
REQ-042 SHALL verify: line 35 → pix_data_req high for h_cnt 143..782, rgb_valid high for 144..783 (640 cycles), pix_x 0..639 and pix_y=0; line 34 and line 515 have no valid.
REQ-043 SHALL verify: enable dropped mid-frame at v_cnt=100 → busy stays 1 until the frame ends, then IDLE with hsync=vsync=0.
REQ-044 SHALL verify: locked dropped during an active pixel → rgb_valid=0 and state IDLE on the next edge; re-lock restarts at h_cnt=v_cnt=0.
REQ-045 SHALL verify: with SYNC_POL=0, hsync/vsync are inverted relative to the SYNC_POL=1 run, with all other outputs identical.
REQ-046 SHALL verify: sys_rst_n pulsed mid-line → all outputs take their reset values asynchronously, and the first RUN cycle after release has h_cnt=0.

Source files
------------

// File: rtl/hdmi_timing_ctrl.sv
// Video timing generator for the HDMI encoder: IDLE/RUN/DRAIN sequencing, sync,
// active-window and one-cycle-early pixel request, all outputs registered.
module hdmi_timing_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_VALID  = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_VALID  = 480,
  parameter int V_TOTAL  = 525,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       locked,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       rgb_valid,
  output logic       pix_data_req,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start,
  output logic       busy
);

  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYN_E = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_B = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_E = HW'(H_SYNC + H_BACK + H_VALID);
  localparam logic [HW-1:0] H_REQ_B = HW'(H_SYNC + H_BACK - 1);
  localparam logic [HW-1:0] H_REQ_E = HW'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYN_E = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_B = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_E = VW'(V_SYNC + V_BACK + V_VALID);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d, h_nxt;
  logic [VW-1:0]   v_q, v_d, v_nxt;
  logic            frame_end;

  logic            hsync_d, vsync_d, rgb_valid_d, req_d, fs_d, busy_d;
  logic [9:0]      pix_x_d, pix_y_d;
  logic            act, v_win;

  always_comb begin
    h_nxt     = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_nxt     = v_q;
    if (h_q == H_LAST) v_nxt = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    frame_end = (h_q == H_LAST) && (v_q == V_LAST);

    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (!locked) begin
      state_d = IDLE;
      h_d     = '0;
      v_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          h_d = '0;
          v_d = '0;
          if (enable) state_d = RUN;
        end
        RUN: begin
          h_d = h_nxt;
          v_d = v_nxt;
          if (!enable) state_d = DRAIN;
        end
        DRAIN: begin
          // a returning enable resumes mid-frame without touching the counters
          if (enable) begin
            state_d = RUN;
            h_d     = h_nxt;
            v_d     = v_nxt;
          end else if (frame_end) begin
            state_d = IDLE;
            h_d     = '0;
            v_d     = '0;
          end else begin
            h_d = h_nxt;
            v_d = v_nxt;
          end
        end
        default: begin
          state_d = IDLE;
          h_d     = '0;
          v_d     = '0;
        end
      endcase
    end
  end

  // outputs are decoded from next-state so the registered value lines up with its counter cycle
  always_comb begin
    act         = (state_d != IDLE);
    v_win       = (v_d >= V_ACT_B) && (v_d < V_ACT_E);
    hsync_d     = (act && (h_d < H_SYN_E)) ? SYNC_POL : ~SYNC_POL;
    vsync_d     = (act && (v_d < V_SYN_E)) ? SYNC_POL : ~SYNC_POL;
    rgb_valid_d = act && v_win && (h_d >= H_ACT_B) && (h_d < H_ACT_E);
    req_d       = act && v_win && (h_d >= H_REQ_B) && (h_d < H_REQ_E);
    pix_x_d     = req_d ? 10'(h_d - H_REQ_B) : '0;
    pix_y_d     = req_d ? 10'(v_d - V_ACT_B) : '0;
    fs_d        = (state_d == RUN) && (h_d == '0) && (v_d == '0);
    busy_d      = act;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      h_q          <= '0;
      v_q          <= '0;
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      rgb_valid    <= 1'b0;
      pix_data_req <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      frame_start  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      hsync        <= hsync_d;
      vsync        <= vsync_d;
      rgb_valid    <= rgb_valid_d;
      pix_data_req <= req_d;
      pix_x        <= pix_x_d;
      pix_y        <= pix_y_d;
      frame_start  <= fs_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Bench for hdmi_timing_ctrl: shrunken timing, both sync polarities side by side,
// checked every cycle against a frame-position model.
module tb_hdmi_timing_ctrl;
  localparam int HS = 4, HB = 3, HV = 10, HT = 20;
  localparam int VS = 2, VB = 3, VV = 6,  VT = 14;
  localparam int FRAME = HT * VT;
  localparam logic [25:0] SYNC_BITS = 26'h3000000;

  logic clk = 1'b0, rst_n, locked, enable;
  always #5 clk = ~clk;

  logic hs_p, vs_p, valid_p, req_p, fs_p, busy_p;
  logic hs_n, vs_n, valid_n, req_n, fs_n, busy_n;
  logic [9:0] px_p, py_p, px_n, py_n;
  logic [25:0] obs_p, obs_n;
  assign obs_p = {hs_p, vs_p, valid_p, req_p, px_p, py_p, fs_p, busy_p};
  assign obs_n = {hs_n, vs_n, valid_n, req_n, px_n, py_n, fs_n, busy_n};

  hdmi_timing_ctrl #(.H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_TOTAL(VT), .SYNC_POL(1'b1)) u_dut_p (
    .vga_clk(clk), .sys_rst_n(rst_n), .locked(locked), .enable(enable),
    .hsync(hs_p), .vsync(vs_p), .rgb_valid(valid_p), .pix_data_req(req_p),
    .pix_x(px_p), .pix_y(py_p), .frame_start(fs_p), .busy(busy_p));

  hdmi_timing_ctrl #(.H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_TOTAL(VT), .SYNC_POL(1'b0)) u_dut_n (
    .vga_clk(clk), .sys_rst_n(rst_n), .locked(locked), .enable(enable),
    .hsync(hs_n), .vsync(vs_n), .rgb_valid(valid_n), .pix_data_req(req_n),
    .pix_x(px_n), .pix_y(py_n), .frame_start(fs_n), .busy(busy_n));

  int n_vec = 0, n_err = 0;
  // model: mode 0 idle / 1 run / 2 drain, pos = cycle index within the frame
  int m_mode = 0, m_pos = 0;

  task automatic model_clk();
    if (!locked) begin
      m_mode = 0; m_pos = 0;
    end else if (m_mode == 0) begin
      if (enable) begin m_mode = 1; m_pos = 0; end
    end else if (m_mode == 2 && !enable && m_pos == FRAME - 1) begin
      m_mode = 0; m_pos = 0;
    end else begin
      m_pos  = (m_pos + 1) % FRAME;
      m_mode = enable ? 1 : 2;
    end
  endtask

  function automatic logic [25:0] exp_vec(input bit pol);
    int h, v;
    bit act, vwin, valid, req;
    logic [9:0] px, py;
    h     = m_pos % HT;
    v     = m_pos / HT;
    act   = (m_mode != 0);
    vwin  = (v >= VS + VB) && (v < VS + VB + VV);
    valid = act && vwin && (h >= HS + HB) && (h < HS + HB + HV);
    req   = act && vwin && (h + 1 >= HS + HB) && (h + 1 < HS + HB + HV);
    px    = req ? 10'(h + 1 - HS - HB) : 10'd0;
    py    = req ? 10'(v - VS - VB) : 10'd0;
    return {((act && h < HS) ? pol : ~pol), ((act && v < VS) ? pol : ~pol),
            valid, req, px, py, (m_mode == 1 && m_pos == 0), act};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_clk();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; locked = 1'b1; enable = 1'b1;
    m_mode = 0; m_pos = 0;
    repeat (3) begin
      tick();
      n_vec++; if (obs_p !== exp_vec(1'b1)) begin n_err++; $display("FAIL reset_p got=%h exp=%h", obs_p, exp_vec(1'b1)); end
      n_vec++; if (obs_n !== exp_vec(1'b0)) begin n_err++; $display("FAIL reset_n got=%h exp=%h", obs_n, exp_vec(1'b0)); end
    end
    locked = 1'b0; enable = 1'b0; rst_n = 1'b1;
    tick();
    n_vec++; if (obs_p !== exp_vec(1'b1)) begin n_err++; $display("FAIL idle_unlocked got=%h exp=%h", obs_p, exp_vec(1'b1)); end
  endtask

  task automatic test_frame();
    int hs_tot = 0, vs_tot = 0, rq_first = -1, rq_last = -1, vd_first = -1;
    int vl[VT];
    logic [9:0] px_first = '1, px_last = '1;
    foreach (vl[i]) vl[i] = 0;
    locked = 1'b1; enable = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      if (c == 0) begin
        n_vec++; if (fs_p !== 1'b1) begin n_err++; $display("FAIL first_run_frame_start got=%b exp=1", fs_p); end
      end
      n_vec++; if (obs_p !== exp_vec(1'b1)) begin n_err++; $display("FAIL frame_p pos=%0d got=%h exp=%h", m_pos, obs_p, exp_vec(1'b1)); end
      n_vec++; if (obs_n !== exp_vec(1'b0)) begin n_err++; $display("FAIL frame_n pos=%0d got=%h exp=%h", m_pos, obs_n, exp_vec(1'b0)); end
      hs_tot += int'(hs_p); vs_tot += int'(vs_p);
      vl[m_pos / HT] += int'(valid_p);
      if (m_pos / HT == VS + VB) begin
        if (req_p && rq_first < 0) begin rq_first = m_pos % HT; px_first = px_p; end
        if (req_p) begin rq_last = m_pos % HT; px_last = px_p; end
        if (valid_p && vd_first < 0) vd_first = m_pos % HT;
      end
    end
    n_vec++; if (hs_tot != HS * VT) begin n_err++; $display("FAIL hsync_count got=%0d exp=%0d", hs_tot, HS * VT); end
    n_vec++; if (vs_tot != VS * HT) begin n_err++; $display("FAIL vsync_count got=%0d exp=%0d", vs_tot, VS * HT); end
    n_vec++; if (vl[VS + VB - 1] != 0) begin n_err++; $display("FAIL line_before_active got=%0d exp=0", vl[VS + VB - 1]); end
    n_vec++; if (vl[VS + VB] != HV) begin n_err++; $display("FAIL first_active_line got=%0d exp=%0d", vl[VS + VB], HV); end
    n_vec++; if (vl[VS + VB + VV] != 0) begin n_err++; $display("FAIL line_after_active got=%0d exp=0", vl[VS + VB + VV]); end
    n_vec++; if (rq_first != HS + HB - 1 || rq_last != HS + HB + HV - 2) begin
      n_err++; $display("FAIL req_window got=%0d..%0d exp=%0d..%0d", rq_first, rq_last, HS + HB - 1, HS + HB + HV - 2); end
    n_vec++; if (vd_first != HS + HB) begin n_err++; $display("FAIL valid_start got=%0d exp=%0d", vd_first, HS + HB); end
    n_vec++; if (px_first !== 10'd0 || px_last !== 10'(HV - 1)) begin
      n_err++; $display("FAIL pix_x_range got=%0d..%0d exp=0..%0d", px_first, px_last, HV - 1); end
  endtask

  task automatic test_drain();
    int p0, cnt = 0;
    locked = 1'b1; enable = 1'b1;
    for (int i = 0; i < 2 * FRAME && m_pos != 5 * HT + 7; i++) tick();
    n_vec++; if (m_pos != 5 * HT + 7) begin n_err++; $display("FAIL drain_setup_timeout pos=%0d exp=%0d", m_pos, 5 * HT + 7); end
    p0 = m_pos;
    enable = 1'b0;
    while (busy_p === 1'b1 && cnt < 2 * FRAME) begin
      tick(); cnt++;
      n_vec++; if (obs_p !== exp_vec(1'b1)) begin n_err++; $display("FAIL drain_p pos=%0d got=%h exp=%h", m_pos, obs_p, exp_vec(1'b1)); end
    end
    n_vec++; if (cnt != FRAME - p0) begin n_err++; $display("FAIL drain_length got=%0d exp=%0d", cnt, FRAME - p0); end
    n_vec++; if ({hs_p, vs_p, busy_p} !== 3'b000) begin n_err++; $display("FAIL drain_idle_out got=%b exp=000", {hs_p, vs_p, busy_p}); end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    enable = 1'b1;
    tick();
    n_vec++; if (fs_p !== 1'b1) begin n_err++; $display("FAIL b2b_start got=%b exp=1", fs_p); end
    do begin
      if (k == 30) enable = 1'b0;
      if (k == 47) enable = 1'b1;
      tick(); k++;
      n_vec++; if (obs_p !== exp_vec(1'b1)) begin n_err++; $display("FAIL b2b_p k=%0d got=%h exp=%h", k, obs_p, exp_vec(1'b1)); end
    end while (fs_p !== 1'b1 && k < 2 * FRAME);
    n_vec++; if (k != FRAME) begin n_err++; $display("FAIL b2b_frame_len got=%0d exp=%0d", k, FRAME); end
  endtask

  task automatic test_lock_loss();
    for (int i = 0; i < 2 * FRAME && valid_p !== 1'b1; i++) tick();
    n_vec++; if (valid_p !== 1'b1) begin n_err++; $display("FAIL lock_setup_timeout got=%b exp=1", valid_p); end
    repeat ($urandom_range(0, 3)) if (m_pos % HT < HS + HB + HV - 5) tick();
    locked = 1'b0;
    tick();
    n_vec++; if ({valid_p, busy_p} !== 2'b00) begin n_err++; $display("FAIL lock_drop got=%b exp=00", {valid_p, busy_p}); end
    n_vec++; if (obs_p !== exp_vec(1'b1)) begin n_err++; $display("FAIL lock_drop_all got=%h exp=%h", obs_p, exp_vec(1'b1)); end
    tick();
    locked = 1'b1;
    tick();
    n_vec++; if ({fs_p, hs_p, busy_p} !== 3'b111) begin n_err++; $display("FAIL relock_start got=%b exp=111", {fs_p, hs_p, busy_p}); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2 * FRAME && !(m_mode == 1 && m_pos % HT == 9); i++) tick();
    #2 rst_n = 1'b0;
    m_mode = 0; m_pos = 0;
    #1;
    n_vec++; if (obs_p !== 26'h0) begin n_err++; $display("FAIL async_rst_p got=%h exp=%h", obs_p, 26'h0); end
    n_vec++; if (obs_n !== SYNC_BITS) begin n_err++; $display("FAIL async_rst_n got=%h exp=%h", obs_n, SYNC_BITS); end
    @(negedge clk);
    tick();
    n_vec++; if (obs_p !== exp_vec(1'b1)) begin n_err++; $display("FAIL rst_hold got=%h exp=%h", obs_p, exp_vec(1'b1)); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (fs_p !== 1'b1) begin n_err++; $display("FAIL post_rst_start got=%b exp=1", fs_p); end
    n_vec++; if (obs_p !== exp_vec(1'b1)) begin n_err++; $display("FAIL post_rst_all got=%h exp=%h", obs_p, exp_vec(1'b1)); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      locked = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 119) == 0) enable = ~enable;
      tick();
      n_vec++; if (obs_p !== exp_vec(1'b1)) begin n_err++; $display("FAIL rand_p c=%0d got=%h exp=%h", c, obs_p, exp_vec(1'b1)); end
      n_vec++; if (obs_n !== exp_vec(1'b0)) begin n_err++; $display("FAIL rand_n c=%0d got=%h exp=%h", c, obs_n, exp_vec(1'b0)); end
      n_vec++; if (obs_n !== (obs_p ^ SYNC_BITS)) begin n_err++; $display("FAIL rand_pol c=%0d got=%h exp=%h", c, obs_n, obs_p ^ SYNC_BITS); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_drain();
    test_back_to_back();
    test_lock_loss();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
